pulse_train_gen: RTL
====================

# pulse_train_gen

Triggered multi-channel pulse-train generator: parametrised successor to the two-pulse generator. A trigger starts one train: optional start delay, then `cfg_count` pulses of `cfg_width` cycles separated by `cfg_gap` cycles. The train is driven onto up to `N_CH` outputs with per-channel enable and per-channel output inversion. It sits between the UART command decoder, which supplies the trigger and configuration words, and the board pulse outputs.

## Interface
- `CNT_W`, 16: width of the delay, width and gap counters and config words.
- `NUM_W`, 8: width of the pulse-count config word.
- `N_CH`, 2: number of output channels.
- `OUT_INV`, `{N_CH{1'b0}}`: per-channel inversion mask. Bit set means the channel is active-low.

Ports:
- `sys_clk`, input, 1: the single clock for the block.
- `sys_rst_n`, input, 1: reset, asynchronous assert, active-low.
- `trig`, input, 1: asynchronous level input. A rising edge requests a train.
- `abort`, input, 1: synchronous. When high, the current train is terminated.
- `retrig_en`, input, 1: selects the response to a trigger during a train. 1 restarts the train; 0 ignores the trigger.
- `cfg_delay`, input, `CNT_W`: start delay in cycles. 0 means no delay.
- `cfg_width`, input, `CNT_W`: pulse width in cycles. Must be at least 1.
- `cfg_gap`, input, `CNT_W`: low time between pulses in cycles. May be 0.
- `cfg_count`, input, `NUM_W`: number of pulses. Must be at least 1.
- `ch_en`, input, `N_CH`: per-channel enable.
- `pulse_out`, output, `N_CH`: registered channel outputs.
- `busy`, output, 1: high while a train is in progress.
- `done`, output, 1: one-cycle strobe when a train completes normally.
- `cfg_err`, output, 1: one-cycle strobe when a trigger is rejected for invalid configuration.
- `pulse_idx`, output, `NUM_W`: index of the current pulse, starting at 0.

## Operation
- Trigger path:
  - `trig` passes through a 2-flop synchronizer and then a rising-edge detector, producing a 1-cycle `trig_rise`.
- Acceptance, on `trig_rise` while in IDLE:
  - If `cfg_width==0` or `cfg_count==0`: assert `cfg_err` for 1 cycle, remain in IDLE, no output activity.
  - Otherwise: latch `cfg_*` and `ch_en` into shadow registers. Config changes mid-train have no effect.
- FSM states: IDLE, DELAY, HIGH, GAP.
  - IDLE: on an accepted trigger, go to DELAY if the latched delay is greater than 0, else go to HIGH.
  - DELAY: held for exactly `cfg_delay` cycles, then go to HIGH.
  - HIGH: held for exactly `cfg_width` cycles. Then:
    - if this is the last pulse, go to IDLE and assert `done` (no trailing gap);
    - else if gap is greater than 0, go to GAP;
    - else go to HIGH again with `pulse_idx+1`. Pulses then merge into one continuous high level.
  - GAP: held for exactly `cfg_gap` cycles, then go to HIGH with `pulse_idx` incremented.
- Counter: one shared `CNT_W` down-counter, loaded on each state entry with (duration − 1). No wrap is possible. A duration of 2^CNT_W−1 is legal.
- Channel output:
  - Raw level is 1 in HIGH, else 0.
  - `pulse_out[i]` = (raw & latched `ch_en[i]`) ^ `OUT_INV[i]`. A disabled channel holds its inactive level for the whole train.
- Retrigger (`trig_rise` while busy):
  - `retrig_en=1`: relatch config and restart from DELAY or HIGH as for acceptance in IDLE. No `done` strobe for the aborted train.
  - `retrig_en=0`: the trigger is ignored.
- Abort:
  - `abort` high in any non-IDLE state: go to IDLE at the next edge, outputs go inactive. No `done`.
  - `abort` has priority over a simultaneous `trig_rise`.
- Reset values:
  - `pulse_out=OUT_INV`.
  - `busy`, `done`, `cfg_err` and `pulse_idx` are 0.
  - FSM in IDLE; synchronizer flops 0.
  - Reset asserted mid-train forces these values immediately, without waiting for a clock.

## Timing
- Trigger latency: `trig` first sampled high at edge k. `trig_rise` is valid during cycle k+1..k+2. The FSM leaves IDLE at edge k+2.
- Start of pulse: with delay 0, `pulse_out` goes active at edge k+3. With delay D, it goes active at edge k+3+D.
- Width and gap: `pulse_out` is active for exactly W cycles and inactive for exactly G cycles between pulses.
- Train length: the last active cycle is followed at the next edge by inactive outputs, `busy=0` and `done=1` for 1 cycle.
- `busy` goes high at edge k+2 and stays high through the last HIGH cycle.
- Back-to-back triggers: a new trigger may be accepted on the cycle after `done`. The minimum `trig` low time is 2 cycles.

## Structure
- Package `pulse_train_pkg` contains:
  - the FSM state enum;
  - default values for `CNT_W` and `NUM_W`;
  - the state-duration load helper constants.
- Sub-module `trig_sync_edge`: 2-flop synchronizer plus rising-edge detector, async active-low reset. It is reused by the UART front end.
- Top level: FSM, shared counter, shadow configuration registers, output register stage.

## Test plan
- Basic train: delay=0, W=5, G=3, count=3, `ch_en=2'b11`, `OUT_INV=0` -> three 5-cycle highs with 3-cycle lows between them. First rise at k+3. `done` one cycle after the last high. Total busy time 21 cycles.
- Delay and inversion: D=4, W=2, G=0, count=2, `OUT_INV=2'b10`, `ch_en=2'b01` -> ch0 high for 4 continuous cycles starting at k+7. ch1 stays at 1 throughout.
- Invalid configuration: W=0, or count=0 -> `cfg_err` 1-cycle strobe, `busy` stays 0, outputs unchanged.
- Retrigger: during pulse 2 of 4, `trig` rises with `retrig_en=1` -> train restarts with `pulse_idx=0` and new config, no `done` in between. Same stimulus with `retrig_en=0` -> original train completes unchanged.
- Abort and reset: `abort` asserted in GAP -> IDLE at the next edge, no `done`. `sys_rst_n` dropped mid-HIGH -> `pulse_out=OUT_INV` immediately.
- Maximum values: W=0xFFFF, count=1 -> exactly 65535 active cycles, counter never wraps.

Source files
------------

// File: rtl/pulse_train_pkg.sv
// Shared types and constants for the triggered pulse-train generator.
package pulse_train_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam int NUM_W_DEF = 8;

  // A state lasting N cycles loads N-DUR_OFS and leaves when the counter hits DUR_LAST.
  localparam int DUR_OFS  = 1;
  localparam int DUR_LAST = 0;

endpackage

// File: rtl/trig_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module trig_sync_edge (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/pulse_train_gen.sv
// Triggered multi-channel pulse-train generator: delay, then count pulses of width
// separated by gap, with per-channel enable and inversion.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int              CNT_W   = CNT_W_DEF,
  parameter int              NUM_W   = NUM_W_DEF,
  parameter int              N_CH    = 2,
  parameter logic [N_CH-1:0] OUT_INV = {N_CH{1'b0}}
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             trig,
  input  logic             abort,
  input  logic             retrig_en,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [NUM_W-1:0] cfg_count,
  input  logic [N_CH-1:0]  ch_en,
  output logic [N_CH-1:0]  pulse_out,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [NUM_W-1:0] pulse_idx
);

  state_e           state, nxt;
  logic [CNT_W-1:0] cnt, ld_val;
  logic             ld, accept, err_set, done_set, idx_inc;
  logic             trig_rise, start_req, cfg_ok, cnt_last, last_pulse, raw_d;
  logic [CNT_W-1:0] wid_s, gap_s;
  logic [NUM_W-1:0] num_s;
  logic [N_CH-1:0]  en_s;
  logic [1:0]       done_pipe;

  trig_sync_edge u_trig (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .din       (trig),
    .rise      (trig_rise)
  );

  assign start_req  = trig_rise && (state == ST_IDLE || retrig_en);
  assign cfg_ok     = (cfg_width != '0) && (cfg_count != '0);
  assign cnt_last   = (cnt == CNT_W'(DUR_LAST));
  assign last_pulse = (pulse_idx == num_s - NUM_W'(1));

  always_comb begin
    nxt      = state;
    ld       = 1'b0;
    ld_val   = '0;
    accept   = 1'b0;
    err_set  = 1'b0;
    done_set = 1'b0;
    idx_inc  = 1'b0;
    if (abort && state != ST_IDLE) begin
      nxt = ST_IDLE;
    end else if (start_req && cfg_ok) begin
      // The delay goes straight into the counter, so it needs no shadow copy.
      accept = 1'b1;
      ld     = 1'b1;
      if (cfg_delay != '0) begin
        nxt    = ST_DELAY;
        ld_val = cfg_delay - CNT_W'(DUR_OFS);
      end else begin
        nxt    = ST_HIGH;
        ld_val = cfg_width - CNT_W'(DUR_OFS);
      end
    end else begin
      err_set = start_req;
      case (state)
        ST_DELAY: if (cnt_last) begin
          nxt    = ST_HIGH;
          ld     = 1'b1;
          ld_val = wid_s - CNT_W'(DUR_OFS);
        end
        ST_HIGH: if (cnt_last) begin
          if (last_pulse) begin
            nxt      = ST_IDLE;
            done_set = 1'b1;
          end else if (gap_s != '0) begin
            nxt    = ST_GAP;
            ld     = 1'b1;
            ld_val = gap_s - CNT_W'(DUR_OFS);
          end else begin
            ld      = 1'b1;
            ld_val  = wid_s - CNT_W'(DUR_OFS);
            idx_inc = 1'b1;
          end
        end
        ST_GAP: if (cnt_last) begin
          nxt     = ST_HIGH;
          ld      = 1'b1;
          ld_val  = wid_s - CNT_W'(DUR_OFS);
          idx_inc = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      wid_s     <= '0;
      gap_s     <= '0;
      num_s     <= '0;
      en_s      <= '0;
      pulse_idx <= '0;
      done_pipe <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state <= nxt;
      if (ld)             cnt <= ld_val;
      else if (!cnt_last) cnt <= cnt - CNT_W'(1);
      if (accept) begin
        wid_s <= cfg_width;
        gap_s <= cfg_gap;
        num_s <= cfg_count;
        en_s  <= ch_en;
      end
      if (accept || nxt == ST_IDLE) pulse_idx <= '0;
      else if (idx_inc)             pulse_idx <= pulse_idx + NUM_W'(1);
      // done lines up with the output stage, which trails the state by one cycle
      done_pipe <= {done_pipe[0], done_set};
      cfg_err   <= err_set;
    end
  end

  assign done  = done_pipe[1];
  assign busy  = (state != ST_IDLE);
  assign raw_d = (state == ST_HIGH) && !abort;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) pulse_out[i] <= OUT_INV[i];
      else            pulse_out[i] <= (raw_d & en_s[i]) ^ OUT_INV[i];
    end
  end

endmodule
